v_sram_mp: RTL
==============

Name: v_sram_mp

Overview:
- Parametrised 2-read/2-write synchronous SRAM model; successor to the fixed 48x512 dual-port model.
- Adds configurable width/depth and registered reads with valid flags.
- Adds deterministic write-collision priority, selectable read-during-write forwarding, and a post-reset memory-clear sequencer.
- Used as the storage primitive for table and buffer blocks in the next SRAM integration.

Parameters:
DATA_W, 48, data word width in bits
ADDR_W, 9, address width in bits
DEPTH, 512, number of words; must be <= 2**ADDR_W
BYPASS, 1, 1 = read-during-write returns new data; 0 = returns old data
INIT_VAL, 0, DATA_W-bit value written to every word after reset

Ports:
clock  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
we1  input  1  write enable, port 1
waddr1  input  ADDR_W  write address, port 1
wdata1  input  DATA_W  write data, port 1
we2  input  1  write enable, port 2
waddr2  input  ADDR_W  write address, port 2
wdata2  input  DATA_W  write data, port 2
re1  input  1  read enable, port 1
raddr1  input  ADDR_W  read address, port 1
rdata1  output  DATA_W  registered read data, port 1
rvalid1  output  1  rdata1 updated this cycle
re2  input  1  read enable, port 2
raddr2  input  ADDR_W  read address, port 2
rdata2  output  DATA_W  registered read data, port 2
rvalid2  output  1  rdata2 updated this cycle
init_busy  output  1  clear sequence in progress; all accesses ignored
wr_conflict  output  1  one-cycle pulse: both write ports hit the same address

Behaviour:
- Reset and outputs:
  - Reset is synchronous and active-high.
  - While reset is sampled high: rdata1/2 = 0, rvalid1/2 = 0, wr_conflict = 0, init_busy = 1, clear counter = 0.
- FSM states: INIT, READY.
  - Reset forces INIT.
  - In INIT, each edge with reset low writes INIT_VAL to word[counter] and increments counter.
  - At the edge that writes word DEPTH-1, FSM moves to READY and init_busy drops to 0.
  - Clear takes exactly DEPTH cycles after reset deasserts.
  - In INIT, we/re inputs are ignored: no writes, rvalid stays 0, wr_conflict stays 0.
  - Reset asserted mid-INIT or in READY restarts the clear from address 0.
- Writes (READY only):
  - weN=1 at an edge writes wdataN to word[waddrN] at that edge.
  - If we1 and we2 are both high and waddr1 == waddr2: port 2 data is stored and wr_conflict = 1 in the following cycle (one cycle only). Otherwise wr_conflict = 0.
  - A write with address >= DEPTH is dropped silently and does not count as a conflict.
- Reads (READY only):
  - Latency is 1. reN=1 at edge E loads rdataN and sets rvalidN=1 for the cycle after E.
  - reN=0 at edge E: rvalidN=0 and rdataN holds its previous value.
  - A read with address >= DEPTH returns 0 with rvalidN=1.
  - Both read ports may address the same word; each returns identical data.
- Read-during-write (raddrN equals an active write address at the same edge):
  - BYPASS=1: rdataN = the data being written; if both write ports hit that address, port 2 data.
  - BYPASS=0: rdataN = word contents before the edge.
- Memory contents persist across READY cycles. Contents are only cleared by the INIT sequence.
- Outputs carry no modelled delays; timing annotation is a synthesis concern.

Test Plan:
- Reset high 2 cycles, then low, with DEPTH=8 -> init_busy = 1 for exactly 8 cycles after deassert; reading all 8 words afterwards returns INIT_VAL with rvalid = 1 one cycle after each re.
- Write 48'hABCDEF012345 to addr 5 via port 1; next cycle read addr 5 on both read ports -> rdata1 = rdata2 = 48'hABCDEF012345, rvalid1 = rvalid2 = 1 exactly one cycle after re.
- we1 = we2 = 1, waddr1 = waddr2 = 3, wdata1 = 1, wdata2 = 2 -> wr_conflict pulses high for 1 cycle; a later read of addr 3 returns 2. Same test with waddr2 = 4 -> no pulse; addr 3 = 1, addr 4 = 2.
- Addr 7 holds 10; write 20 to addr 7 while reading addr 7 at the same edge -> BYPASS=1 returns 20; BYPASS=0 returns 10; the following read returns 20 in both builds.
- With DEPTH=8 and ADDR_W=4: write 9 to addr 12, then read addr 12 -> rdata = 0, rvalid = 1, no wr_conflict, and words 0-7 are unchanged.
- Assert reset at clear counter = 4, hold 1 cycle -> counter restarts at 0 and init_busy stays high a full DEPTH cycles; a read issued during INIT gives rvalid = 0.

Source files
------------

// File: rtl/v_sram_mp.sv
// v_sram_mp: parametrised 2-read/2-write synchronous SRAM with registered
// reads, deterministic write-collision priority (port 2 wins), selectable
// read-during-write forwarding and a post-reset clear sequencer.
module v_sram_mp #(
  parameter int                DATA_W   = 48,
  parameter int                ADDR_W   = 9,
  parameter int                DEPTH    = 512,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid2,
  output logic              init_busy,
  output logic              wr_conflict
);

  localparam int             IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready;
  logic              w1_ok, w2_ok, w1_en, same_w, conflict_d;
  logic [1:0]        re_v;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd_d [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [1:0]        rvalid_q;
  logic              conflict_q;

  // Addresses at or beyond DEPTH do not exist: writes drop, reads return 0.
  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  assign ready = (state_q == READY);
  assign re_v  = {re2, re1};
  assign ra[0] = raddr1;
  assign ra[1] = raddr2;

  // Write qualification: port 1 yields to port 2 on a same-address collision.
  always_comb begin
    w1_ok      = ready && we1 && in_rng(waddr1);
    w2_ok      = ready && we2 && in_rng(waddr2);
    same_w     = (waddr1 == waddr2);
    w1_en      = w1_ok && !(w2_ok && same_w);
    conflict_d = w1_ok && w2_ok && same_w;
  end

  // Read data selection, optionally forwarding same-edge write data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = '0;
      if (in_rng(ra[p])) begin
        rd_d[p] = mem_q[ra[p][IDX_W-1:0]];
        if (BYPASS != 0) begin
          if (w1_en && (waddr1 == ra[p])) rd_d[p] = wdata1;
          if (w2_ok && (waddr2 == ra[p])) rd_d[p] = wdata2;
        end
      end
    end
  end

  // Clear sequencer next-state: walk every word once, then go live.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Clear sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array: clear writes during INIT, user writes once READY.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= INIT_VAL;
      end else begin
        if (w1_en) mem_q[waddr1[IDX_W-1:0]] <= wdata1;
        if (w2_ok) mem_q[waddr2[IDX_W-1:0]] <= wdata2;
      end
    end
  end

  // Registered read outputs and collision pulse; data holds when not read.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      rvalid_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_q[p] <= ready && re_v[p];
        if (ready && re_v[p]) rdata_q[p] <= rd_d[p];
      end
      conflict_q <= conflict_d;
    end
  end

  assign rdata1      = rdata_q[0];
  assign rdata2      = rdata_q[1];
  assign rvalid1     = rvalid_q[0];
  assign rvalid2     = rvalid_q[1];
  assign init_busy   = (state_q == INIT);
  assign wr_conflict = conflict_q;

endmodule
